// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - period-synchronous PWM top/compare register owner with per-channel duty ramping
module pwm_ramp_ctrl #(
  parameter int n        = 1,
  parameter int m        = 10,
  parameter int CW       = 1,
  parameter int TOP_INIT = 1023
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           period_end,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_sel,
  input  logic [CW-1:0]  cmd_chan,
  input  logic [m-1:0]   cmd_value,
  input  logic [m-1:0]   cmd_step,
  output logic [m-1:0]   top,
  output logic [m*n-1:0] comp,
  output logic [n-1:0]   ramp_done,
  output logic           busy
);

  localparam logic [m-1:0] TOP_RST = m'(TOP_INIT);

  typedef enum logic {IDLE, PEND} state_t;

  state_t         state_q, state_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           sh_sel_q, sh_sel_d;
  logic [CW-1:0]  sh_chan_q, sh_chan_d;
  logic [m-1:0]   sh_value_q, sh_value_d;
  logic [m-1:0]   sh_step_q, sh_step_d;
  logic [m-1:0]   top_q, top_d;
  logic [m-1:0]   cur_q [n];
  logic [m-1:0]   cur_d [n];
  logic [m-1:0]   tgt_q [n];
  logic [m-1:0]   tgt_d [n];
  logic [m-1:0]   step_q [n];
  logic [m-1:0]   step_d [n];

  logic [m-1:0]   diff;
  logic [m-1:0]   clamp;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    sh_sel_d    = sh_sel_q;
    sh_chan_d   = sh_chan_q;
    sh_value_d  = sh_value_q;
    sh_step_d   = sh_step_q;
    top_d       = top_q;
    cur_d       = cur_q;
    tgt_d       = tgt_q;
    step_d      = step_q;
    diff        = '0;
    clamp       = (sh_value_q > top_q) ? top_q : sh_value_q;

    // Ramp from pre-apply values; difference taken first so nothing wraps or overshoots
    if (period_end) begin
      for (int i = 0; i < n; i++) begin
        if (cur_q[i] < tgt_q[i]) begin
          diff = tgt_q[i] - cur_q[i];
          cur_d[i] = (diff <= step_q[i]) ? tgt_q[i] : cur_q[i] + step_q[i];
        end else if (cur_q[i] > tgt_q[i]) begin
          diff = cur_q[i] - tgt_q[i];
          cur_d[i] = (diff <= step_q[i]) ? tgt_q[i] : cur_q[i] - step_q[i];
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          sh_sel_d    = cmd_sel;
          sh_chan_d   = cmd_chan;
          sh_value_d  = cmd_value;
          sh_step_d   = cmd_step;
          state_d     = PEND;
          cmd_ready_d = 1'b0;
        end
      end
      PEND: begin
        if (period_end) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          if (sh_sel_q) begin
            top_d = sh_value_q;
            for (int i = 0; i < n; i++) begin
              if (cur_d[i] > sh_value_q) cur_d[i] = sh_value_q;
              if (tgt_d[i] > sh_value_q) tgt_d[i] = sh_value_q;
            end
          end else begin
            // Out-of-range channels match no index and are simply consumed
            for (int i = 0; i < n; i++) begin
              if (sh_chan_q == CW'(i)) begin
                tgt_d[i]  = clamp;
                step_d[i] = sh_step_q;
                if (sh_step_q == '0) cur_d[i] = clamp;
              end
            end
          end
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      sh_sel_q    <= 1'b0;
      sh_chan_q   <= '0;
      sh_value_q  <= '0;
      sh_step_q   <= '0;
      top_q       <= TOP_RST;
      for (int i = 0; i < n; i++) begin
        cur_q[i]  <= '0;
        tgt_q[i]  <= '0;
        step_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      sh_sel_q    <= sh_sel_d;
      sh_chan_q   <= sh_chan_d;
      sh_value_q  <= sh_value_d;
      sh_step_q   <= sh_step_d;
      top_q       <= top_d;
      cur_q       <= cur_d;
      tgt_q       <= tgt_d;
      step_q      <= step_d;
    end
  end

  always_comb begin
    comp      = '0;
    ramp_done = '0;
    for (int i = 0; i < n; i++) begin
      comp[i*m +: m] = cur_q[i];
      ramp_done[i]   = (cur_q[i] == tgt_q[i]);
    end
  end

  assign top       = top_q;
  assign cmd_ready = cmd_ready_q;
  assign busy      = (state_q == PEND) | ~&ramp_done;

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Configuration and sequencing controller for the team's PWM generators (sawtooth or up/down counter, n channels, m-bit compare).
- Owns the `top` and per-channel `comp` buses the PWM consumes.
- Applies host updates only on the PWM period boundary, so there are no glitched periods.
- Ramps each channel's compare value toward a target by a programmable step once per period (soft start / soft duty changes).

Parameters:
- n, 1, number of PWM channels
- m, 10, counter/compare width in bits
- CW, 1, channel-select width; 2^CW >= n required
- TOP_INIT, 1023, `top` value after reset; must be < 2^m

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous active-low reset
- period_end  in  1  one-cycle pulse from the PWM counter at period wrap (counter == top)
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  controller can accept a command
- cmd_sel  in  1  0 = channel duty command, 1 = top (period) command
- cmd_chan  in  CW  target channel (ignored when cmd_sel=1)
- cmd_value  in  m  new target compare value, or new top
- cmd_step  in  m  ramp step per period; 0 = jump immediately (ignored when cmd_sel=1)
- top  out  m  period register driven to the PWM
- comp  out  m*n  concatenated current compare values; channel i at bits [i*m +: m]
- ramp_done  out  n  bit i = 1 when channel i current == target
- busy  out  1  command pending, or any channel ramping

Interface (already decided): one clock, `clk`; reset `rst_n` is synchronous and active-low.

Behaviour:
- **Reset** (rst_n=0 at posedge):
  - top=TOP_INIT
  - all cur/target/step = 0, so comp = 0
  - ramp_done = all 1s
  - cmd_ready=1, busy=0
  - pending command discarded
  - Reset overrides every other input on that edge.
- **Command FSM, two states:**
  - IDLE: cmd_ready=1. When cmd_valid is high, latch sel/chan/value/step into the shadow register and go to PEND.
  - PEND: cmd_ready=0. On period_end, apply the shadow command and return to IDLE; cmd_ready is 1 in the next cycle.
  - Exactly one command is in flight at a time.
- **Boundary rule:** a command latched on the same edge that period_end is high is not applied on that edge. It waits for the next period_end, so every command spans at least one full period boundary.
- **Apply, channel command (cmd_sel=0, cmd_chan<n):**
  - target[chan] = min(value, top).
  - step[chan] = cmd_step.
  - If cmd_step=0, cur[chan] = target on the same edge.
- **Apply, out-of-range channel (cmd_chan >= n):** command consumed with no register effect; FSM still returns to IDLE on period_end.
- **Apply, top command (cmd_sel=1):**
  - top = value.
  - On the same edge, every channel's target and cur are clamped to min(existing, new top).
  - Steps are unchanged.
- **Ramp**, on each period_end, per channel, using pre-apply values:
  - if cur<target: cur = (target-cur <= step) ? target : cur+step
  - if cur>target: cur = (cur-target <= step) ? target : cur-step
  - Never overshoot; no wrap; arithmetic is in m bits, with the difference computed before comparison.
- **Precedence on one edge with period_end:** the ramp is computed from old values, then the applied command's writes override that channel (or clamp all channels on a top command).
- **No period_end:** cur, target, top and comp hold indefinitely; a pending command stays pending with cmd_ready=0.
- **Outputs:**
  - comp mirrors cur registers directly (registered, no extra latency); a ramp step is visible the cycle after the period_end edge.
  - ramp_done[i] = (cur[i]==target[i]), registered-equivalent (derived from registers).
  - busy = PEND | ~&ramp_done.
- period_end asserted for multiple consecutive cycles is treated as multiple boundaries (one ramp step per high cycle).

Test Plan:
- **Reset values:** hold rst_n=0 for 3 cycles, then release → top=1023, comp=0, ramp_done=1, cmd_ready=1, busy=0.
- **Deferred jump:** channel 0 command, value=500, step=0; no period_end for 20 cycles → comp unchanged at 0, cmd_ready=0. Pulse period_end → comp[0]=500 the next cycle, cmd_ready=1, ramp_done[0]=1.
- **Ramp up with clamp:** cur=0, target=100, step=30 → successive period_end pulses give comp 30, 60, 90, 100, 100; busy drops after the 4th pulse.
- **Ramp down:** from 100, command target=10, step=40 → apply edge produces no step. Subsequent pulses give 60, 20, 10.
- **Top shrink clamps:** ch0 cur=target=800; top command value=400 → on the apply edge top=400, comp[0]=400. A later channel command with value=900 → target clamped to 400.
- **Simultaneous and edge cases:**
  - cmd_valid coincides with period_end → not applied until the following period_end.
  - cmd_chan=1 with n=1 → accepted, no effect, cmd_ready returns after the next period_end.
  - rst_n low while in PEND → command discarded, comp=0.
